// File: rtl/mod_cu.sv
// Control unit for the repeated-subtraction modulo datapath.
// It latches one operand pair, drives the datapath mux and temp write enable, then returns the remainder, quotient and error code.
module mod_cu #(
  parameter int QW         = 32,
  parameter int ITER_LIMIT = 0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   a_in,
  input  logic [31:0]   b_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   rem_out,
  output logic [QW-1:0] quot_out,
  output logic [1:0]    err_out,
  output logic          busy,
  output logic [31:0]   dp_a,
  output logic [31:0]   dp_b,
  output logic          dp_s,
  output logic          dp_we,
  input  logic          dp_is_less,
  input  logic [31:0]   dp_result
);

  typedef enum logic [1:0] {IDLE, FIRST, ITER, DONE} state_t;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_DIV0  = 2'b01;
  localparam logic [1:0] ERR_NEG   = 2'b10;
  localparam logic [1:0] ERR_LIMIT = 2'b11;

  localparam bit          LIMIT_EN = (ITER_LIMIT != 0);
  localparam logic [QW-1:0] LIMIT  = QW'(ITER_LIMIT);

  state_t        state, state_nxt;
  logic [31:0]   a_reg, b_reg, a_nxt, b_nxt;
  logic [QW-1:0] cnt, cnt_nxt;
  logic [31:0]   rem_nxt;
  logic [QW-1:0] quot_nxt;
  logic [1:0]    err_nxt;
  logic          limit_hit;

  assign dp_a      = a_reg;
  assign dp_b      = b_reg;
  assign out_valid = (state == DONE);
  assign limit_hit = LIMIT_EN && (cnt == LIMIT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      cnt      <= '0;
      rem_out  <= '0;
      quot_out <= '0;
      err_out  <= ERR_OK;
    end else begin
      state    <= state_nxt;
      a_reg    <= a_nxt;
      b_reg    <= b_nxt;
      cnt      <= cnt_nxt;
      rem_out  <= rem_nxt;
      quot_out <= quot_nxt;
      err_out  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    a_nxt     = a_reg;
    b_nxt     = b_reg;
    cnt_nxt   = cnt;
    rem_nxt   = rem_out;
    quot_nxt  = quot_out;
    err_nxt   = err_out;
    in_ready  = 1'b0;
    busy      = 1'b0;
    dp_s      = 1'b0;
    dp_we     = 1'b0;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_nxt    = a_in;
          b_nxt    = b_in;
          cnt_nxt  = '0;
          rem_nxt  = '0;
          quot_nxt = '0;
          if (b_in == 32'd0) begin
            err_nxt   = ERR_DIV0;
            state_nxt = DONE;
          end else if (a_in[31] || b_in[31]) begin
            err_nxt   = ERR_NEG;
            state_nxt = DONE;
          end else begin
            err_nxt   = ERR_OK;
            state_nxt = FIRST;
          end
        end
      end

      // The datapath temp register is not reset, so the first compare must use a.
      FIRST: begin
        busy = 1'b1;
        if (dp_is_less) begin
          rem_nxt   = a_reg;
          quot_nxt  = '0;
          err_nxt   = ERR_OK;
          state_nxt = DONE;
        end else begin
          dp_we     = 1'b1;
          cnt_nxt   = QW'(1);
          state_nxt = ITER;
        end
      end

      ITER: begin
        busy = 1'b1;
        dp_s = 1'b1;
        if (dp_is_less) begin
          rem_nxt   = dp_result;
          quot_nxt  = cnt;
          err_nxt   = ERR_OK;
          state_nxt = DONE;
        end else if (limit_hit) begin
          rem_nxt   = '0;
          quot_nxt  = cnt;
          err_nxt   = ERR_LIMIT;
          state_nxt = DONE;
        end else begin
          dp_we   = 1'b1;
          cnt_nxt = cnt + QW'(1);
        end
      end

      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mod_cu.sv
// Bench for mod_cu: one unlimited and one ITER_LIMIT=4 instance share stimulus, each paired with a small datapath model.
// Expected results come from plain division arithmetic rather than from the FSM.
module tb_mod_cu;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a_in, b_in;

  logic        in_ready_u, out_valid_u, busy_u, s_u, we_u, less_u;
  logic [31:0] rem_u, quot_u, dpa_u, dpb_u, temp_u, mux_u;
  logic [1:0]  err_u;

  logic        in_ready_l, out_valid_l, busy_l, s_l, we_l, less_l;
  logic [31:0] rem_l, quot_l, dpa_l, dpb_l, temp_l, mux_l;
  logic [1:0]  err_l;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mod_cu #(.QW(32), .ITER_LIMIT(0)) dut_u (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready_u),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid_u), .out_ready(out_ready),
    .rem_out(rem_u), .quot_out(quot_u), .err_out(err_u), .busy(busy_u),
    .dp_a(dpa_u), .dp_b(dpb_u), .dp_s(s_u), .dp_we(we_u),
    .dp_is_less(less_u), .dp_result(temp_u)
  );

  mod_cu #(.QW(32), .ITER_LIMIT(4)) dut_l (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready_l),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid_l), .out_ready(out_ready),
    .rem_out(rem_l), .quot_out(quot_l), .err_out(err_l), .busy(busy_l),
    .dp_a(dpa_l), .dp_b(dpb_l), .dp_s(s_l), .dp_we(we_l),
    .dp_is_less(less_l), .dp_result(temp_l)
  );

  // Datapath behaviour: compare the selected operand against b; subtract b into temp when enabled.
  assign mux_u  = s_u ? temp_u : dpa_u;
  assign less_u = (mux_u < dpb_u);
  always @(posedge CLK) if (we_u) temp_u <= mux_u - dpb_u;

  assign mux_l  = s_l ? temp_l : dpa_l;
  assign less_l = (mux_l < dpb_l);
  always @(posedge CLK) if (we_l) temp_l <= mux_l - dpb_l;

  typedef struct packed {
    logic [31:0] rem;
    logic [31:0] quot;
    logic [1:0]  err;
    logic [31:0] lat;
    logic [31:0] wes;
  } exp_t;

  function automatic exp_t refModel(input logic [31:0] a, input logic [31:0] b, input int limit);
    exp_t e;
    logic [31:0] q;
    e = '0;
    if (b == 32'd0) begin
      e.err = 2'b01; e.lat = 1;
    end else if (a[31] || b[31]) begin
      e.err = 2'b10; e.lat = 1;
    end else begin
      q = a / b;
      if (limit != 0 && q > 32'(limit)) begin
        e.err = 2'b11; e.quot = 32'(limit); e.lat = 32'(limit) + 2; e.wes = 32'(limit);
      end else begin
        e.rem = a % b; e.quot = q; e.lat = q + 2; e.wes = q;
      end
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full operation on both instances; called at a negedge with both units idle.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    exp_t eu, el;
    int latU, latL, weU, weL, bad;
    eu = refModel(a, b, 0);
    el = refModel(a, b, 4);
    latU = 0; latL = 0; weU = 0; weL = 0; bad = 0;
    checkOutput("in_ready_u idle", 64'(in_ready_u), 64'd1);
    checkOutput("in_ready_l idle", 64'(in_ready_l), 64'd1);
    in_valid = 1'b1; a_in = a; b_in = b;
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      if (we_u) weU++;
      if (we_l) weL++;
      if (we_u && (less_u || out_valid_u || in_ready_u)) bad++;
      if (we_l && (less_l || out_valid_l || in_ready_l)) bad++;
      if (busy_u !== !out_valid_u || in_ready_u !== 1'b0) bad++;
      if (busy_l !== !out_valid_l || in_ready_l !== 1'b0) bad++;
      if (out_valid_u && latU == 0) latU = c;
      if (out_valid_l && latL == 0) latL = c;
      if (latU != 0 && latL != 0) break;
      @(negedge CLK);
    end
    if (latU == 0 || latL == 0) checkOutput("done timeout", 64'd0, 64'd1);
    checkOutput($sformatf("lat_u a=%0h b=%0h", a, b), 64'(latU), 64'(eu.lat));
    checkOutput($sformatf("lat_l a=%0h b=%0h", a, b), 64'(latL), 64'(el.lat));
    checkOutput($sformatf("rem_u a=%0h b=%0h", a, b), 64'(rem_u), 64'(eu.rem));
    checkOutput($sformatf("rem_l a=%0h b=%0h", a, b), 64'(rem_l), 64'(el.rem));
    checkOutput($sformatf("quot_u a=%0h b=%0h", a, b), 64'(quot_u), 64'(eu.quot));
    checkOutput($sformatf("quot_l a=%0h b=%0h", a, b), 64'(quot_l), 64'(el.quot));
    checkOutput($sformatf("err_u a=%0h b=%0h", a, b), 64'(err_u), 64'(eu.err));
    checkOutput($sformatf("err_l a=%0h b=%0h", a, b), 64'(err_l), 64'(el.err));
    checkOutput($sformatf("we_u count a=%0h b=%0h", a, b), 64'(weU), 64'(eu.wes));
    checkOutput($sformatf("we_l count a=%0h b=%0h", a, b), 64'(weL), 64'(el.wes));
    checkOutput("protocol violations", 64'(bad), 64'd0);
    checkOutput("dp_a_u", 64'(dpa_u), 64'(a));
    checkOutput("dp_b_l", 64'(dpb_l), 64'(b));
    out_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    out_ready = 1'b0;
    checkOutput("out_valid_u released", 64'(out_valid_u), 64'd0);
    checkOutput("out_valid_l released", 64'(out_valid_l), 64'd0);
    checkOutput("in_ready_u released", 64'(in_ready_u), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] ra, rb;
    bit seen;
    RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkOutput("reset in_ready", 64'(in_ready_u), 64'd1);
    checkOutput("reset out_valid", 64'(out_valid_u), 64'd0);
    checkOutput("reset rem", 64'(rem_u), 64'd0);
    checkOutput("reset quot", 64'(quot_u), 64'd0);
    checkOutput("reset err", 64'(err_u), 64'd0);
    checkOutput("reset busy", 64'(busy_u), 64'd0);
    checkOutput("reset dp_a", 64'(dpa_u), 64'd0);
    checkOutput("reset dp_we", 64'(we_u), 64'd0);
    RST = 1'b0;
    @(negedge CLK);

    $display("[TB] directed operations");
    applyStimulus(32'd17, 32'd5);
    applyStimulus(32'd3, 32'd7);
    applyStimulus(32'd20, 32'd5);
    applyStimulus(32'd100, 32'd0);
    applyStimulus(32'h8000_0000, 32'd5);
    applyStimulus(32'd5, 32'h8000_0000);
    applyStimulus(32'd100, 32'd1);
    applyStimulus(32'd0, 32'd3);
    applyStimulus(32'd12, 32'd12);
    applyStimulus(32'd24, 32'd5);

    // Result held under back-pressure while new operands are offered.
    $display("[TB] back-pressure hold");
    in_valid = 1'b1; a_in = 32'd17; b_in = 32'd5;
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid_u) begin
        seen = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    checkOutput("hold done seen", 64'(seen), 64'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a_in = $urandom_range(0, 50);
      b_in = 32'd1;
      @(negedge CLK);
      checkOutput("hold out_valid", 64'(out_valid_u), 64'd1);
      checkOutput("hold in_ready", 64'(in_ready_u), 64'd0);
      checkOutput("hold rem", 64'(rem_u), 64'd2);
      checkOutput("hold quot", 64'(quot_u), 64'd3);
      checkOutput("hold err", 64'(err_u), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    out_ready = 1'b0;
    checkOutput("hold release in_ready", 64'(in_ready_u), 64'd1);
    checkOutput("hold release busy", 64'(busy_u), 64'd0);
    applyStimulus(32'd10, 32'd3);

    // Reset while iterating discards the operation.
    $display("[TB] reset mid-operation");
    in_valid = 1'b1; a_in = 32'd1000; b_in = 32'd3;
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (5) @(negedge CLK);
    checkOutput("pre-reset busy", 64'(busy_u), 64'd1);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    checkOutput("mid reset out_valid_u", 64'(out_valid_u), 64'd0);
    checkOutput("mid reset out_valid_l", 64'(out_valid_l), 64'd0);
    checkOutput("mid reset in_ready", 64'(in_ready_u), 64'd1);
    checkOutput("mid reset busy", 64'(busy_u), 64'd0);
    checkOutput("mid reset quot", 64'(quot_u), 64'd0);
    checkOutput("mid reset dp_b", 64'(dpb_u), 64'd0);
    repeat (3) begin
      @(negedge CLK);
      checkOutput("post reset quiet", 64'(out_valid_u), 64'd0);
    end
    applyStimulus(32'd10, 32'd3);

    $display("[TB] random operations");
    for (int n = 0; n < 25; n++) begin
      ra = $urandom_range(0, 300);
      rb = $urandom_range(0, 12);
      if ($urandom_range(0, 9) == 0) ra[31] = 1'b1;
      if ($urandom_range(0, 14) == 0) rb[31] = 1'b1;
      applyStimulus(ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
